mat_lane_alu: RTL and testbench

//  Lane-wise matrix element ALU between the DRAM agent's operand outputs and its write-back input.
//  - Takes one 512-bit word from matrix A and one from matrix B per handshake.
//  - Applies the run's operation to each 32-bit lane and returns the 512-bit result word.
//  - Counts result words against the run length and raises done when the last word has left.

---
 rtl/mat_alu_pkg.sv | 22 ++
 rtl/mat_lane_op.sv | 67 ++++++
 rtl/mat_lane_alu.sv | 131 +++++++++++++
 tb/tb_mat_lane_alu.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_alu_pkg.sv
// Shared types and constants for the lane-wise matrix ALU (mat_lane_alu and mat_lane_op).
package mat_alu_pkg;

    localparam int LANE_W = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_MAX = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    localparam logic [LANE_W-1:0] SAT_MAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] SAT_MIN = {1'b1, {(LANE_W-1){1'b0}}};

endpackage

// File: rtl/mat_lane_op.sv
// Combinational single-lane signed op with overflow flag.
// Defining MAT_ALU_SAT_EN clamps overflowing add/sub/mul results instead of wrapping.
module mat_lane_op
    import mat_alu_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  alu_op_e           op,
    output logic [LANE_W-1:0] res,
    output logic              ovf
);

    localparam int MSB = LANE_W - 1;

    logic [LANE_W-1:0]          sum;
    logic [LANE_W-1:0]          diff;
    logic signed [2*LANE_W-1:0] prod;
    logic                       add_ovf;
    logic                       sub_ovf;
    logic                       mul_ovf;

    assign sum  = a + b;
    assign diff = a - b;
    assign prod = (2*LANE_W)'($signed(a)) * (2*LANE_W)'($signed(b));

    assign add_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
    assign sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
    // The product fits only if its upper half and the low-half sign bit are all equal.
    assign mul_ovf = !(&prod[2*LANE_W-1:MSB]) && (|prod[2*LANE_W-1:MSB]);

    always_comb begin
        res = sum;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                res = sum;
                ovf = add_ovf;
`ifdef MAT_ALU_SAT_EN
                if (add_ovf) res = a[MSB] ? SAT_MIN : SAT_MAX;
`endif
            end
            OP_SUB: begin
                res = diff;
                ovf = sub_ovf;
`ifdef MAT_ALU_SAT_EN
                if (sub_ovf) res = a[MSB] ? SAT_MIN : SAT_MAX;
`endif
            end
            OP_MUL: begin
                res = prod[MSB:0];
                ovf = mul_ovf;
`ifdef MAT_ALU_SAT_EN
                if (mul_ovf) res = prod[2*LANE_W-1] ? SAT_MIN : SAT_MAX;
`endif
            end
            OP_MAX: begin
                res = ($signed(a) > $signed(b)) ? a : b;
                ovf = 1'b0;
            end
            default: begin
                res = sum;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mat_lane_alu.sv
// Lane-wise matrix element ALU: two-stage pipeline, run FSM and word counters.
// Optional saturation of add/sub/mul is enabled by defining MAT_ALU_SAT_EN.
module mat_lane_alu
    import mat_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int LEN_W      = 28
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [LEN_W-1:0]      mat_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ovf,
    output logic [LEN_W-1:0]      words_done,
    output logic                  done
);

    localparam int LANES = DATA_WIDTH / LANE_W;

    state_e                state;
    alu_op_e               op_q;
    alu_op_e               s1_op;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      words_in;
    logic                  s1_v;
    logic                  s2_v;
    logic [DATA_WIDTH-1:0] s1_a;
    logic [DATA_WIDTH-1:0] s1_b;
    logic [DATA_WIDTH-1:0] s2_data;
    logic [DATA_WIDTH-1:0] lane_res;
    logic [LANES-1:0]      lane_ovf;
    logic                  s1_load;
    logic                  s2_load;
    logic                  in_fire;
    logic                  out_fire;
    logic                  last_out;

    assign s2_load   = !s2_v || out_ready;
    assign s1_load   = !s1_v || s2_load;
    assign in_ready  = (state == S_RUN) && s1_load && (words_in < len_q);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = s2_v && out_ready;
    assign last_out  = out_fire && ((words_done + LEN_W'(1)) == len_q);
    assign out_valid = s2_v;
    assign out_data  = s2_data;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mat_lane_op u_lane_op (
            .a   (s1_a[i*LANE_W +: LANE_W]),
            .b   (s1_b[i*LANE_W +: LANE_W]),
            .op  (s1_op),
            .res (lane_res[i*LANE_W +: LANE_W]),
            .ovf (lane_ovf[i])
        );
    end

    // Run control; start wins over everything else and discards in-flight work.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            op_q       <= OP_ADD;
            len_q      <= '0;
            words_in   <= '0;
            words_done <= '0;
            ovf        <= 1'b0;
            done       <= 1'b0;
        end else if (start) begin
            op_q       <= alu_op_e'(op);
            len_q      <= mat_len;
            words_in   <= '0;
            words_done <= '0;
            ovf        <= 1'b0;
            if (mat_len != '0) begin
                state <= S_RUN;
                done  <= 1'b0;
            end else begin
                state <= S_DONE;
                done  <= 1'b1;
            end
        end else begin
            if (in_fire) words_in <= words_in + LEN_W'(1);
            if (out_fire && (words_done < len_q)) words_done <= words_done + LEN_W'(1);
            if (s2_load && s1_v && (|lane_ovf)) ovf <= 1'b1;
            case (state)
                S_RUN: begin
                    if (last_out) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_op   <= OP_ADD;
            s2_data <= '0;
        end else if (start) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_v <= in_fire;
                if (in_fire) begin
                    s1_a  <= in_a;
                    s1_b  <= in_b;
                    s1_op <= op_q;
                end
            end
            if (s2_load) begin
                s2_v <= s1_v;
                if (s1_v) s2_data <= lane_res;
            end
        end
    end

endmodule

// File: tb/tb_mat_lane_alu.sv
// Randomized and directed bench for mat_lane_alu against a 64-bit arithmetic lane model.
// Expected values follow MAT_ALU_SAT_EN when the macro is defined for the build.
module tb_mat_lane_alu;

    localparam int DW    = 512;
    localparam int LW    = 32;
    localparam int LANES = DW / LW;
    localparam int LENW  = 28;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [1:0]      op;
    logic [LENW-1:0] mat_len;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_a;
    logic [DW-1:0]   in_b;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            ovf;
    logic [LENW-1:0] words_done;
    logic            done;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [DW-1:0] expq[$];
    int            acc;
    int            got;
    int            runLen;
    logic [1:0]    runOp;
    bit            modelOvf;
    bit            prevStall;
    logic [DW-1:0] prevData;
    logic [DW-1:0] lastOut;
    logic [DW-1:0] w;

    always #5 clk = ~clk;

    mat_lane_alu #(.DATA_WIDTH(DW), .LEN_W(LENW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .op         (op),
        .mat_len    (mat_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .ovf        (ovf),
        .words_done (words_done),
        .done       (done)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] laneModel(input logic [1:0] o, input logic [LW-1:0] a,
                                                input logic [LW-1:0] b, output bit of);
        longint x, y, r;
        x  = longint'($signed(a));
        y  = longint'($signed(b));
        of = 1'b0;
        case (o)
            2'd0:    r = x + y;
            2'd1:    r = x - y;
            2'd2:    r = x * y;
            default: r = (x > y) ? x : y;
        endcase
        if (o != 2'd3 && (r > 64'sd2147483647 || r < -64'sd2147483648)) begin
            of = 1'b1;
`ifdef MAT_ALU_SAT_EN
            r = (r > 0) ? 64'sd2147483647 : -64'sd2147483648;
`endif
        end
        return r[LW-1:0];
    endfunction

    function automatic logic [DW-1:0] wordModel(input logic [1:0] o, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b, output bit anyOf);
        logic [DW-1:0] r;
        bit            of;
        anyOf = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            r[i*LW +: LW] = laneModel(o, a[i*LW +: LW], b[i*LW +: LW], of);
            anyOf |= of;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] fill(input logic [LW-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*LW +: LW] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] randWord();
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) begin
            case ($urandom_range(0, 3))
                0:       r[i*LW +: LW] = $urandom();
                1:       r[i*LW +: LW] = 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
                2:       r[i*LW +: LW] = 32'($urandom_range(0, 2000));
                default: r[i*LW +: LW] = -32'($urandom_range(0, 2000));
            endcase
        end
        return r;
    endfunction

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    task automatic startRun(input logic [1:0] o, input int len);
        @(negedge clk);
        start     = 1'b1;
        op        = o;
        mat_len   = LENW'(len);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        runOp     = o;
        runLen    = len;
        acc       = 0;
        got       = 0;
        modelOvf  = 1'b0;
        prevStall = 1'b0;
        expq.delete();
        qa.delete();
        qb.delete();
    endtask

    // One clock of traffic: drive at the falling edge, observe after settling.
    task automatic applyStimulus(input bit iv, input bit ordy);
        bit lo;
        @(negedge clk);
        start     = 1'b0;
        op        = 2'($urandom());
        mat_len   = LENW'($urandom_range(0, 20));
        in_valid  = iv && (acc < qa.size());
        if (acc < qa.size()) begin
            in_a = qa[acc];
            in_b = qb[acc];
        end
        out_ready = ordy;
        #1;
        if (prevStall) begin
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_data", out_data, prevData);
        end
        if (acc >= runLen) checkOutput("in_ready_limit", in_ready, 0);
        checkOutput("words_done_run", words_done, got);
        if (out_valid) checkOutput("done_early", done, 0);
        if (in_valid && in_ready) begin
            w = wordModel(runOp, in_a, in_b, lo);
            modelOvf |= lo;
            expq.push_back(w);
            acc++;
        end
        if (out_valid && out_ready) begin
            lastOut = out_data;
            if (expq.size() == 0) checkOutput("extra_out", out_valid, 0);
            else checkOutput("data", out_data, expq.pop_front());
            got++;
        end
        prevStall = out_valid && !out_ready;
        prevData  = out_data;
    endtask

    task automatic runLoop(input int vp, input int rp, input int budget);
        int n = 0;
        while (got < runLen && n < budget) begin
            applyStimulus(pct(vp), pct(rp));
            n++;
        end
        checkOutput("run_complete", got, runLen);
    endtask

    task automatic finishRun();
        @(negedge clk);
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checkOutput("done", done, 1);
        checkOutput("words_done_end", words_done, runLen);
        checkOutput("ovf_end", ovf, modelOvf);
        checkOutput("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        op        = 2'd0;
        mat_len   = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        acc       = 0;
        got       = 0;
        runLen    = 0;
        runOp     = 2'd0;
        modelOvf  = 1'b0;
        prevStall = 1'b0;
        prevData  = '0;
        lastOut   = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_words_done", words_done, 0);
        checkOutput("rst_done", done, 0);
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b1;
        #1;
        checkOutput("idle_in_ready", in_ready, 0);

        // Add with two-cycle latency
        startRun(2'd0, 1);
        qa.push_back(fill(32'd5));
        qb.push_back(fill(32'd7));
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("lat_s1", out_valid, 0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("lat_s2", out_valid, 1);
        checkOutput("add_lanes", lastOut, fill(32'd12));
        finishRun();

        // Backpressure on a subtract run
        startRun(2'd1, 4);
        for (int i = 0; i < 4; i++) begin
            qa.push_back(randWord());
            qb.push_back(randWord());
        end
        repeat (6) applyStimulus(1'b1, 1'b0);
        checkOutput("bp_accepts", acc, 2);
        checkOutput("bp_in_ready", in_ready, 0);
        runLoop(100, 100, 50);
        finishRun();

        // Signed overflow on lane 0
        startRun(2'd0, 1);
        w = fill(32'd10);
        w[31:0] = 32'h7FFF_FFFF;
        qa.push_back(w);
        qb.push_back(fill(32'd1));
        runLoop(100, 100, 20);
`ifdef MAT_ALU_SAT_EN
        checkOutput("ovf_lane0", lastOut[31:0], 32'h7FFF_FFFF);
`else
        checkOutput("ovf_lane0", lastOut[31:0], 32'h8000_0000);
`endif
        checkOutput("ovf_lane1", lastOut[63:32], 32'd11);
        finishRun();
        checkOutput("ovf_flag", ovf, 1);

        // Multiply and max
        startRun(2'd2, 1);
        qa.push_back(fill(-32'sd3));
        qb.push_back(fill(32'd4));
        runLoop(100, 100, 20);
        checkOutput("mul_lane", lastOut[31:0], 32'hFFFF_FFF4);
        finishRun();
        checkOutput("mul_ovf", ovf, 0);

        startRun(2'd3, 1);
        qa.push_back(fill(32'hFFFF_FFFF));
        qb.push_back(fill(32'd2));
        runLoop(100, 100, 20);
        checkOutput("max_lane", lastOut[31:0], 32'd2);
        finishRun();
        checkOutput("max_ovf", ovf, 0);

        // Length limit with in_valid held beyond the run length
        startRun(2'd0, 2);
        for (int i = 0; i < 5; i++) begin
            qa.push_back(randWord());
            qb.push_back(randWord());
        end
        repeat (5) applyStimulus(1'b1, 1'b1);
        checkOutput("len_accepts", acc, 2);
        runLoop(100, 100, 20);
        finishRun();

        // Randomized runs over all ops
        for (int t = 0; t < 12; t++) begin
            startRun(2'(t % 4), $urandom_range(1, 8));
            for (int i = 0; i < runLen; i++) begin
                qa.push_back(randWord());
                qb.push_back(randWord());
            end
            runLoop($urandom_range(40, 100), $urandom_range(40, 100), 400);
            finishRun();
        end

        // Restart with zero length while words are in flight
        startRun(2'd0, 6);
        for (int i = 0; i < 6; i++) begin
            qa.push_back(randWord());
            qb.push_back(randWord());
        end
        repeat (3) applyStimulus(1'b1, 1'b0);
        startRun(2'd1, 0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("zero_done", done, 1);
        checkOutput("zero_out_valid", out_valid, 0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("zero_out_valid2", out_valid, 0);
        checkOutput("zero_ovf", ovf, 0);

        // Asynchronous reset in the middle of a run
        startRun(2'd2, 6);
        for (int i = 0; i < 6; i++) begin
            qa.push_back(randWord());
            qb.push_back(randWord());
        end
        repeat (3) applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_out_data", out_data, 0);
        checkOutput("mid_rst_in_ready", in_ready, 0);
        checkOutput("mid_rst_ovf", ovf, 0);
        checkOutput("mid_rst_words_done", words_done, 0);
        checkOutput("mid_rst_done", done, 0);
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", in_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
